// File: rtl/cp0_intr_ctrl_if.sv
// CP0 register-write and commit bus plus the readback outputs of the
// interrupt controller. The pipeline side is the master, the controller
// the slave.
//
// Handshake: there is no valid/ready pair. we_i is a single-cycle write
// strobe that qualifies waddr_i and wdata_i. exc_flag_i and eret_i are
// single-cycle commit pulses. The controller never stalls, so each is
// taken at the next rising edge unconditionally.
interface cp0_intr_ctrl_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        exc_flag_i;
    logic        eret_i;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [7:0]  cause_ip_o;
    logic        ti_o;
    logic        intr_o;

    modport master (
        output we_i, waddr_i, wdata_i, exc_flag_i, eret_i,
        input  count_o, compare_o, status_o, cause_ip_o, ti_o, intr_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, exc_flag_i, eret_i,
        output count_o, compare_o, status_o, cause_ip_o, ti_o, intr_o
    );
endinterface

// File: rtl/cp0_intr_ctrl.sv
// CP0 Count/Compare timer, Status/Cause interrupt state and the registered
// interrupt request to the exception unit.
module cp0_intr_ctrl #(
    parameter int COUNT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           hw_int_i,
    cp0_intr_ctrl_if.slave       bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [3:0] DIV_MAX     = 4'(COUNT_DIV - 1);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic [5:0]  sync1_q, sync1_d;
    logic [5:0]  sync2_q, sync2_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        intr_q, intr_d;

    logic        wr_count, wr_compare, wr_status, wr_cause;
    logic        inc_tick;
    logic [31:0] count_inc;
    logic [7:0]  ip;

    // Decode writes, divider tick and the assembled Cause.IP vector.
    always_comb begin
        wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
        wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
        wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
        wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
        inc_tick   = (div_q == DIV_MAX);
        count_inc  = count_q + 32'd1;
        ip         = {sync2_q[5] | ti_q, sync2_q[4:0], ip_sw_q};
    end

    // Next-state logic; a Count write beats an increment, a Compare write
    // beats a match, and exception commit beats ERET beats a Status write
    // for EXL only.
    always_comb begin
        div_d     = inc_tick ? 4'd0 : div_q + 4'd1;
        count_d   = inc_tick ? count_inc : count_q;
        if (wr_count) begin
            div_d   = 4'd0;
            count_d = bus.wdata_i;
        end

        compare_d = wr_compare ? bus.wdata_i : compare_q;

        ti_d = ti_q;
        if (wr_compare)
            ti_d = 1'b0;
        else if (inc_tick && !wr_count && (count_inc == compare_q))
            ti_d = 1'b1;

        sync1_d = hw_int_i;
        sync2_d = sync1_q;

        ip_sw_d = wr_cause ? bus.wdata_i[9:8] : ip_sw_q;
        im_d    = wr_status ? bus.wdata_i[15:8] : im_q;
        ie_d    = wr_status ? bus.wdata_i[0] : ie_q;

        if (bus.exc_flag_i)
            exl_d = 1'b1;
        else if (bus.eret_i)
            exl_d = 1'b0;
        else if (wr_status)
            exl_d = bus.wdata_i[1];
        else
            exl_d = exl_q;

        intr_d = ie_q & ~exl_q & (|(ip & im_q));
    end

    // State registers with synchronous reset that overrides all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
            sync1_q   <= 6'd0;
            sync2_q   <= 6'd0;
            ip_sw_q   <= 2'd0;
            im_q      <= 8'd0;
            exl_q     <= 1'b1;
            ie_q      <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ip_sw_q   <= ip_sw_d;
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            intr_q    <= intr_d;
        end
    end

    // Register readback.
    always_comb begin
        bus.count_o    = count_q;
        bus.compare_o  = compare_q;
        bus.status_o   = {16'd0, im_q, 6'd0, exl_q, ie_q};
        bus.cause_ip_o = ip;
        bus.ti_o       = ti_q;
        bus.intr_o     = intr_q;
    end
endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl with COUNT_DIV=2.
module tb_cp0_intr_ctrl;
    logic       clk;
    logic       rst;
    logic [5:0] hw_int;
    int         errors;
    int         checks;

    cp0_intr_ctrl_if bus ();

    cp0_intr_ctrl #(.COUNT_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .hw_int_i (hw_int),
        .bus      (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle MTC0 write, applied at the next edge.
    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = addr;
        bus.wdata_i = data;
        step();
        bus.we_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.we_i    = 1'b1;
        bus.waddr_i = 5'd12;
        bus.wdata_i = 32'hFFFF_FFFF;
        bus.eret_i  = 1'b1;
        step();
        step();
        checks++; if (bus.count_o !== 32'd0) begin errors++; $display("FAIL reset_count got=%h exp=%h", bus.count_o, 32'd0); end
        checks++; if (bus.compare_o !== 32'd0) begin errors++; $display("FAIL reset_compare got=%h exp=%h", bus.compare_o, 32'd0); end
        checks++; if (bus.status_o !== 32'h0000_0002) begin errors++; $display("FAIL reset_status got=%h exp=%h", bus.status_o, 32'h2); end
        checks++; if (bus.cause_ip_o !== 8'h00) begin errors++; $display("FAIL reset_cause got=%h exp=%h", bus.cause_ip_o, 8'h0); end
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL reset_ti got=%b exp=0", bus.ti_o); end
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL reset_intr got=%b exp=0", bus.intr_o); end
        bus.we_i   = 1'b0;
        bus.eret_i = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_timer_match();
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        for (int i = 0; i < 9; i++) step();
        checks++; if (bus.count_o !== 32'd4) begin errors++; $display("FAIL timer_count9 got=%0d exp=4", bus.count_o); end
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL timer_ti_early got=%b exp=0", bus.ti_o); end
        step();
        checks++; if (bus.count_o !== 32'd5) begin errors++; $display("FAIL timer_count10 got=%0d exp=5", bus.count_o); end
        checks++; if (bus.ti_o !== 1'b1) begin errors++; $display("FAIL timer_ti got=%b exp=1", bus.ti_o); end
        checks++; if (bus.cause_ip_o[7] !== 1'b1) begin errors++; $display("FAIL timer_ip7 got=%b exp=1", bus.cause_ip_o[7]); end
    endtask

    task automatic test_timer_intr();
        wr(5'd12, 32'h0000_8001);
        checks++; if (bus.status_o !== 32'h0000_8001) begin errors++; $display("FAIL tintr_status got=%h exp=%h", bus.status_o, 32'h8001); end
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL tintr_early got=%b exp=0", bus.intr_o); end
        step();
        checks++; if (bus.intr_o !== 1'b1) begin errors++; $display("FAIL tintr_set got=%b exp=1", bus.intr_o); end
        wr(5'd11, 32'd9);
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL tintr_ti_clr got=%b exp=0", bus.ti_o); end
        checks++; if (bus.cause_ip_o[7] !== 1'b0) begin errors++; $display("FAIL tintr_ip7_clr got=%b exp=0", bus.cause_ip_o[7]); end
        checks++; if (bus.intr_o !== 1'b1) begin errors++; $display("FAIL tintr_hold got=%b exp=1", bus.intr_o); end
        step();
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL tintr_clr got=%b exp=0", bus.intr_o); end
    endtask

    task automatic test_hw_int();
        wr(5'd11, 32'hFFFF_0000);
        wr(5'd9, 32'd0);
        wr(5'd12, 32'h0000_0401);
        step();
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL hw_idle got=%b exp=0", bus.intr_o); end
        hw_int = 6'b000001;
        step();
        checks++; if (bus.cause_ip_o[2] !== 1'b0) begin errors++; $display("FAIL hw_ip_n got=%b exp=0", bus.cause_ip_o[2]); end
        step();
        checks++; if (bus.cause_ip_o !== 8'h04) begin errors++; $display("FAIL hw_ip_n1 got=%h exp=%h", bus.cause_ip_o, 8'h04); end
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL hw_intr_n1 got=%b exp=0", bus.intr_o); end
        step();
        checks++; if (bus.intr_o !== 1'b1) begin errors++; $display("FAIL hw_intr_n2 got=%b exp=1", bus.intr_o); end
        bus.exc_flag_i = 1'b1;
        step();
        bus.exc_flag_i = 1'b0;
        checks++; if (bus.status_o !== 32'h0000_0403) begin errors++; $display("FAIL hw_exl_set got=%h exp=%h", bus.status_o, 32'h403); end
        step();
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL hw_intr_exc got=%b exp=0", bus.intr_o); end
        bus.eret_i = 1'b1;
        step();
        bus.eret_i = 1'b0;
        checks++; if (bus.status_o !== 32'h0000_0401) begin errors++; $display("FAIL hw_exl_clr got=%h exp=%h", bus.status_o, 32'h401); end
        step();
        checks++; if (bus.intr_o !== 1'b1) begin errors++; $display("FAIL hw_intr_eret got=%b exp=1", bus.intr_o); end
        hw_int = 6'b000000;
        step();
        step();
        step();
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL hw_intr_drop got=%b exp=0", bus.intr_o); end
    endtask

    task automatic test_collisions();
        // Count write while the divider is idle clears it: next tick is two edges out.
        wr(5'd9, 32'd300);
        step();
        checks++; if (bus.count_o !== 32'd300) begin errors++; $display("FAIL div_clear got=%0d exp=300", bus.count_o); end
        step();
        checks++; if (bus.count_o !== 32'd301) begin errors++; $display("FAIL div_tick got=%0d exp=301", bus.count_o); end
        // Count write on an increment tick.
        wr(5'd9, 32'd100);
        step();
        wr(5'd9, 32'd200);
        checks++; if (bus.count_o !== 32'd200) begin errors++; $display("FAIL cnt_wr_tick got=%0d exp=200", bus.count_o); end
        step();
        step();
        checks++; if (bus.count_o !== 32'd201) begin errors++; $display("FAIL cnt_after_wr got=%0d exp=201", bus.count_o); end
        // Compare write on a match edge.
        wr(5'd11, 32'd50);
        wr(5'd9, 32'd49);
        step();
        wr(5'd11, 32'd50);
        checks++; if (bus.count_o !== 32'd50) begin errors++; $display("FAIL cmp_col_count got=%0d exp=50", bus.count_o); end
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL cmp_col_ti got=%b exp=0", bus.ti_o); end
        // Equality created by a Count write does not set TI.
        wr(5'd9, 32'd50);
        step();
        step();
        checks++; if (bus.count_o !== 32'd51) begin errors++; $display("FAIL eq_nowrap_count got=%0d exp=51", bus.count_o); end
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL eq_no_inc_ti got=%b exp=0", bus.ti_o); end
    endtask

    task automatic test_exl_priority();
        bus.exc_flag_i = 1'b1;
        bus.eret_i     = 1'b1;
        wr(5'd12, 32'h0000_0400);
        bus.exc_flag_i = 1'b0;
        bus.eret_i     = 1'b0;
        checks++; if (bus.status_o !== 32'h0000_0402) begin errors++; $display("FAIL exc_wins got=%h exp=%h", bus.status_o, 32'h402); end
        bus.eret_i = 1'b1;
        wr(5'd12, 32'h0000_0403);
        bus.eret_i = 1'b0;
        checks++; if (bus.status_o !== 32'h0000_0401) begin errors++; $display("FAIL eret_over_wr got=%h exp=%h", bus.status_o, 32'h401); end
    endtask

    task automatic test_regs_misc();
        wr(5'd13, 32'hFFFF_FFFF);
        checks++; if (bus.cause_ip_o !== 8'h03) begin errors++; $display("FAIL cause_sw got=%h exp=%h", bus.cause_ip_o, 8'h03); end
        wr(5'd10, 32'hFFFF_FFFF);
        checks++; if (bus.compare_o !== 32'd50) begin errors++; $display("FAIL unimpl_cmp got=%h exp=%h", bus.compare_o, 32'd50); end
        checks++; if (bus.status_o !== 32'h0000_0401) begin errors++; $display("FAIL unimpl_status got=%h exp=%h", bus.status_o, 32'h401); end
        checks++; if (bus.cause_ip_o !== 8'h03) begin errors++; $display("FAIL unimpl_cause got=%h exp=%h", bus.cause_ip_o, 8'h03); end
        wr(5'd13, 32'h0000_0000);
        checks++; if (bus.cause_ip_o !== 8'h00) begin errors++; $display("FAIL cause_sw_clr got=%h exp=%h", bus.cause_ip_o, 8'h00); end
    endtask

    task automatic test_reset_mid();
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd3);
        wr(5'd9, 32'd0);
        for (int i = 0; i < 6; i++) step();
        checks++; if (bus.ti_o !== 1'b1) begin errors++; $display("FAIL mid_pre_ti got=%b exp=1", bus.ti_o); end
        step();
        checks++; if (bus.intr_o !== 1'b1) begin errors++; $display("FAIL mid_pre_intr got=%b exp=1", bus.intr_o); end
        rst            = 1'b1;
        bus.exc_flag_i = 1'b1;
        wr(5'd9, 32'h1234_5678);
        bus.exc_flag_i = 1'b0;
        checks++; if (bus.count_o !== 32'd0) begin errors++; $display("FAIL mid_count got=%h exp=0", bus.count_o); end
        checks++; if (bus.compare_o !== 32'd0) begin errors++; $display("FAIL mid_compare got=%h exp=0", bus.compare_o); end
        checks++; if (bus.status_o !== 32'h0000_0002) begin errors++; $display("FAIL mid_status got=%h exp=%h", bus.status_o, 32'h2); end
        checks++; if (bus.cause_ip_o !== 8'h00) begin errors++; $display("FAIL mid_cause got=%h exp=0", bus.cause_ip_o); end
        checks++; if (bus.ti_o !== 1'b0) begin errors++; $display("FAIL mid_ti got=%b exp=0", bus.ti_o); end
        checks++; if (bus.intr_o !== 1'b0) begin errors++; $display("FAIL mid_intr got=%b exp=0", bus.intr_o); end
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.count_o !== 32'd1) begin errors++; $display("FAIL post_rst_count got=%0d exp=1", bus.count_o); end
    endtask

    // Test sequence.
    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        hw_int         = 6'd0;
        bus.we_i       = 1'b0;
        bus.waddr_i    = 5'd0;
        bus.wdata_i    = 32'd0;
        bus.exc_flag_i = 1'b0;
        bus.eret_i     = 1'b0;
        #2;
        test_reset();
        test_timer_match();
        test_timer_intr();
        test_hw_int();
        test_collisions();
        test_exl_priority();
        test_regs_misc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
